// File: rtl/alu_op_pkg.sv
// Shared types and constants for the EX-stage ALU operation controller:
// operation codes (base + RV32M), controller states, ALUOp and Funct7 encodings.
package alu_op_pkg;

  localparam logic [1:0] ALUOP_MEM = 2'b00;
  localparam logic [1:0] ALUOP_BR  = 2'b01;
  localparam logic [1:0] ALUOP_RI  = 2'b10;
  localparam logic [1:0] ALUOP_JL  = 2'b11;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef enum logic [4:0] {
    OP_AND    = 5'b00000,
    OP_OR     = 5'b00001,
    OP_ADD    = 5'b00010,
    OP_SUB    = 5'b00011,
    OP_SLL    = 5'b00100,
    OP_SRL    = 5'b00101,
    OP_SRA    = 5'b00111,
    OP_BEQ    = 5'b01000,
    OP_XOR    = 5'b01001,
    OP_SLT    = 5'b01100,
    OP_SLTU   = 5'b01101,
    OP_MUL    = 5'b10000,
    OP_MULH   = 5'b10001,
    OP_MULHSU = 5'b10010,
    OP_MULHU  = 5'b10011,
    OP_DIV    = 5'b10100,
    OP_DIVU   = 5'b10101,
    OP_REM    = 5'b10110,
    OP_REMU   = 5'b10111
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL_WAIT,
    ST_DIV_WAIT,
    ST_DONE
  } state_e;

  // Funct3 -> base op; is_sub/is_sra select the alternate encodings of 000/101.
  function automatic op_e base_op(input logic [2:0] f3, input logic is_sub, input logic is_sra);
    op_e op;
    case (f3)
      3'b000:  op = is_sub ? OP_SUB : OP_ADD;
      3'b001:  op = OP_SLL;
      3'b010:  op = OP_SLT;
      3'b011:  op = OP_SLTU;
      3'b100:  op = OP_XOR;
      3'b101:  op = is_sra ? OP_SRA : OP_SRL;
      3'b110:  op = OP_OR;
      default: op = OP_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Pure combinational ALUOp/Funct7/Funct3 decode into an operation code plus
// mul/div class and illegal flags. M decode exists only when RV32M_EN is defined.
module alu_op_decode
  import alu_op_pkg::*;
#(
  parameter int OP_W = 5
) (
  input  logic [1:0]      alu_op_i,
  input  logic [6:0]      funct7_i,
  input  logic [2:0]      funct3_i,
  input  logic            is_rtype_i,
  output logic [OP_W-1:0] op_o,
  output logic            is_mul_o,
  output logic            is_div_o,
  output logic            illegal_o
);

  op_e  op;
  logic f7_base;
  logic f7_alt;
  logic f7_md;
  logic is_shift;

  assign f7_base  = (funct7_i == F7_BASE);
  assign f7_alt   = (funct7_i == F7_ALT);
  assign f7_md    = (funct7_i == F7_MULDIV);
  assign is_shift = (funct3_i[1:0] == 2'b01);

  always_comb begin
    op        = OP_ADD;
    is_mul_o  = 1'b0;
    is_div_o  = 1'b0;
    illegal_o = 1'b0;
    case (alu_op_i)
      ALUOP_MEM, ALUOP_JL: op = OP_ADD;
      ALUOP_BR:            op = OP_BEQ;
      default: begin
        if (is_rtype_i) begin
          if (f7_base || f7_alt) begin
            op = base_op(funct3_i, f7_alt && (funct3_i == 3'b000),
                         f7_alt && (funct3_i == 3'b101));
          end else if (f7_md) begin
`ifdef RV32M_EN
            op       = op_e'({2'b10, funct3_i});
            is_mul_o = ~funct3_i[2];
            is_div_o = funct3_i[2];
`else
            illegal_o = 1'b1;
`endif
          end else begin
            illegal_o = 1'b1;
          end
        end else if (is_shift && !(f7_base || f7_alt)) begin
          illegal_o = 1'b1;
        end else begin
          // Immediate forms never produce SUB: ADDI ignores its upper bits.
          op = base_op(funct3_i, 1'b0, (funct3_i == 3'b101) && f7_alt);
        end
      end
    endcase
  end

  assign op_o = OP_W'(op);

endmodule

// File: rtl/alu_op_ctrl.sv
// Registered ALU op controller: decodes the EX instruction and sequences RV32M
// mul/div through a start/done handshake with pipeline stall. Feature macro: RV32M_EN.
module alu_op_ctrl
  import alu_op_pkg::*;
#(
  parameter int OP_W        = 5,
  parameter int MUL_CYCLES  = 3,
  parameter int DIV_TIMEOUT = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            valid_i,
  input  logic            flush_i,
  input  logic [1:0]      ALUOp,
  input  logic [6:0]      Funct7,
  input  logic [2:0]      Funct3,
  input  logic            is_rtype_i,
  output logic [OP_W-1:0] op_o,
  output logic            op_valid_o,
  output logic            stall_o,
  output logic            md_start_o,
  input  logic            md_done_i,
  output logic            illegal_o,
  output logic            timeout_o
);

  logic [OP_W-1:0] dec_op;
  logic            dec_mul;
  logic            dec_div;
  logic            dec_illegal;

  logic [OP_W-1:0] op_q;
  logic            op_valid_q;
  logic            illegal_q;

  alu_op_decode #(.OP_W(OP_W)) u_decode (
    .alu_op_i   (ALUOp),
    .funct7_i   (Funct7),
    .funct3_i   (Funct3),
    .is_rtype_i (is_rtype_i),
    .op_o       (dec_op),
    .is_mul_o   (dec_mul),
    .is_div_o   (dec_div),
    .illegal_o  (dec_illegal)
  );

  assign op_o       = op_q;
  assign op_valid_o = op_valid_q;
  assign illegal_o  = illegal_q;

`ifdef RV32M_EN
  localparam int              DIV_CW   = (DIV_TIMEOUT > 2) ? $clog2(DIV_TIMEOUT) : 1;
  localparam logic [3:0]      MUL_LOAD = 4'(MUL_CYCLES - 1);
  localparam logic [DIV_CW-1:0] DIV_LAST = DIV_CW'(DIV_TIMEOUT - 1);

  state_e            state_q;
  logic [3:0]        mul_cnt_q;
  logic [DIV_CW-1:0] div_cnt_q;
  logic              stall_q;
  logic              md_start_q;
  logic              timeout_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      op_q       <= '0;
      op_valid_q <= 1'b0;
      illegal_q  <= 1'b0;
      stall_q    <= 1'b0;
      md_start_q <= 1'b0;
      timeout_q  <= 1'b0;
      mul_cnt_q  <= '0;
      div_cnt_q  <= '0;
    end else begin
      op_valid_q <= 1'b0;
      illegal_q  <= 1'b0;
      md_start_q <= 1'b0;
      timeout_q  <= 1'b0;
      if (flush_i) begin
        state_q   <= ST_IDLE;
        stall_q   <= 1'b0;
        mul_cnt_q <= '0;
        div_cnt_q <= '0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (valid_i) begin
              op_q <= dec_op;
              if (dec_illegal) begin
                illegal_q <= 1'b1;
              end else if (dec_mul) begin
                state_q    <= ST_MUL_WAIT;
                md_start_q <= 1'b1;
                stall_q    <= 1'b1;
                mul_cnt_q  <= MUL_LOAD;
              end else if (dec_div) begin
                state_q    <= ST_DIV_WAIT;
                md_start_q <= 1'b1;
                stall_q    <= 1'b1;
                div_cnt_q  <= '0;
              end else begin
                op_valid_q <= 1'b1;
              end
            end
          end
          ST_MUL_WAIT: begin
            if (mul_cnt_q == 4'd0) begin
              state_q    <= ST_DONE;
              op_valid_q <= 1'b1;
              stall_q    <= 1'b0;
            end else begin
              mul_cnt_q <= mul_cnt_q - 4'd1;
            end
          end
          ST_DIV_WAIT: begin
            // A done arriving on the timeout cycle still completes the op.
            if (md_done_i) begin
              state_q    <= ST_DONE;
              op_valid_q <= 1'b1;
              stall_q    <= 1'b0;
              div_cnt_q  <= '0;
            end else if (div_cnt_q == DIV_LAST) begin
              state_q   <= ST_IDLE;
              timeout_q <= 1'b1;
              stall_q   <= 1'b0;
              div_cnt_q <= '0;
            end else begin
              div_cnt_q <= div_cnt_q + 1'b1;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign stall_o    = stall_q;
  assign md_start_o = md_start_q;
  assign timeout_o  = timeout_q;
`else
  logic unused_cfg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_q       <= '0;
      op_valid_q <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      op_valid_q <= 1'b0;
      illegal_q  <= 1'b0;
      if (valid_i && !flush_i) begin
        op_q       <= dec_op;
        illegal_q  <= dec_illegal;
        op_valid_q <= ~dec_illegal;
      end
    end
  end

  assign stall_o    = 1'b0;
  assign md_start_o = 1'b0;
  assign timeout_o  = 1'b0;
  assign unused_cfg = md_done_i ^ dec_mul ^ dec_div ^ (MUL_CYCLES > 0) ^ (DIV_TIMEOUT > 0);
`endif

endmodule

// File: tb/tb_alu_op_ctrl.sv
// Directed self-checking bench for alu_op_ctrl; the M-extension sequences are
// exercised only when RV32M_EN is defined, otherwise Funct7=0000001 must be illegal.
module tb_alu_op_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       valid_i = 1'b0;
  logic       flush_i = 1'b0;
  logic [1:0] ALUOp = 2'b00;
  logic [6:0] Funct7 = 7'b0;
  logic [2:0] Funct3 = 3'b0;
  logic       is_rtype_i = 1'b0;
  logic       md_done_i = 1'b0;
  logic [4:0] op_o;
  logic       op_valid_o;
  logic       stall_o;
  logic       md_start_o;
  logic       illegal_o;
  logic       timeout_o;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_op_ctrl #(.OP_W(5), .MUL_CYCLES(3), .DIV_TIMEOUT(64)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .valid_i    (valid_i),
    .flush_i    (flush_i),
    .ALUOp      (ALUOp),
    .Funct7     (Funct7),
    .Funct3     (Funct3),
    .is_rtype_i (is_rtype_i),
    .op_o       (op_o),
    .op_valid_o (op_valid_o),
    .stall_o    (stall_o),
    .md_start_o (md_start_o),
    .md_done_i  (md_done_i),
    .illegal_o  (illegal_o),
    .timeout_o  (timeout_o)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [4:0] op, input logic v,
                            input logic st, input logic ms, input logic il, input logic to);
    check({tag, ".op"},       32'(op_o),       32'(op));
    check({tag, ".op_valid"}, 32'(op_valid_o), 32'(v));
    check({tag, ".stall"},    32'(stall_o),    32'(st));
    check({tag, ".md_start"}, 32'(md_start_o), 32'(ms));
    check({tag, ".illegal"},  32'(illegal_o),  32'(il));
    check({tag, ".timeout"},  32'(timeout_o),  32'(to));
    $display("txn %-14s op=%05b v=%0b st=%0b ms=%0b il=%0b to=%0b", tag,
             op_o, op_valid_o, stall_o, md_start_o, illegal_o, timeout_o);
  endtask

  task automatic issue(input logic [1:0] aop, input logic [6:0] f7, input logic [2:0] f3,
                       input logic rt);
    ALUOp = aop;
    Funct7 = f7;
    Funct3 = f3;
    is_rtype_i = rt;
    valid_i = 1'b1;
    step();
    valid_i = 1'b0;
  endtask

  initial begin
    // reset
    step();
    step();
    check_outs("reset", 5'b00000, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    step();

    // base decode, one cycle latency, single-cycle op_valid pulse
    issue(2'b10, 7'b0100000, 3'b000, 1'b1);
    check_outs("sub_r", 5'b00011, 1, 0, 0, 0, 0);
    step();
    check_outs("sub_hold", 5'b00011, 0, 0, 0, 0, 0);
    issue(2'b10, 7'b0100000, 3'b000, 1'b0);
    check_outs("addi_alt", 5'b00010, 1, 0, 0, 0, 0);
    issue(2'b01, 7'b0000000, 3'b000, 1'b0);
    check_outs("beq", 5'b01000, 1, 0, 0, 0, 0);
    issue(2'b00, 7'b0100000, 3'b111, 1'b0);
    check_outs("mem_add", 5'b00010, 1, 0, 0, 0, 0);
    issue(2'b10, 7'b0100000, 3'b101, 1'b1);
    check_outs("sra_r", 5'b00111, 1, 0, 0, 0, 0);
    issue(2'b11, 7'b1111111, 3'b110, 1'b0);
    check_outs("jal_add", 5'b00010, 1, 0, 0, 0, 0);
    issue(2'b10, 7'b1010101, 3'b011, 1'b0);
    check_outs("sltu_i", 5'b01101, 1, 0, 0, 0, 0);
    issue(2'b10, 7'b0000000, 3'b100, 1'b1);
    check_outs("xor_r", 5'b01001, 1, 0, 0, 0, 0);
    issue(2'b10, 7'b0000000, 3'b101, 1'b0);
    check_outs("srl_i", 5'b00101, 1, 0, 0, 0, 0);

    // illegal decodes force ADD with no op_valid
    issue(2'b10, 7'b0000010, 3'b101, 1'b1);
    check_outs("ill_shift_r", 5'b00010, 0, 0, 0, 1, 0);
    step();
    check_outs("ill_clear", 5'b00010, 0, 0, 0, 0, 0);
    issue(2'b10, 7'b0000000, 3'b110, 1'b1);
    check_outs("or_r", 5'b00001, 1, 0, 0, 0, 0);
    issue(2'b10, 7'b0000010, 3'b101, 1'b0);
    check_outs("ill_shift_i", 5'b00010, 0, 0, 0, 1, 0);
    issue(2'b10, 7'b0010000, 3'b000, 1'b1);
    check_outs("ill_f7_r", 5'b00010, 0, 0, 0, 1, 0);

    // flush together with valid discards the instruction
    issue(2'b10, 7'b0000000, 3'b100, 1'b1);
    check_outs("xor_again", 5'b01001, 1, 0, 0, 0, 0);
    flush_i = 1'b1;
    issue(2'b10, 7'b0100000, 3'b000, 1'b1);
    check_outs("flush_valid", 5'b01001, 0, 0, 0, 0, 0);
    issue(2'b10, 7'b0010000, 3'b000, 1'b1);
    check_outs("flush_illegal", 5'b01001, 0, 0, 0, 0, 0);
    flush_i = 1'b0;

`ifndef RV32M_EN
    issue(2'b10, 7'b0000001, 3'b000, 1'b1);
    check_outs("m_disabled", 5'b00010, 0, 0, 0, 1, 0);
    issue(2'b10, 7'b0000001, 3'b100, 1'b1);
    check_outs("div_disabled", 5'b00010, 0, 0, 0, 1, 0);
`else
    // MUL: start at T+1, stall T+1..T+3, result at T+4; valid while stalled ignored
    issue(2'b10, 7'b0000001, 3'b000, 1'b1);
    check_outs("mul_t1", 5'b10000, 0, 1, 1, 0, 0);
    ALUOp = 2'b10; Funct7 = 7'b0100000; Funct3 = 3'b000; valid_i = 1'b1;
    step();
    check_outs("mul_t2", 5'b10000, 0, 1, 0, 0, 0);
    step();
    check_outs("mul_t3", 5'b10000, 0, 1, 0, 0, 0);
    valid_i = 1'b0;
    step();
    check_outs("mul_t4", 5'b10000, 1, 0, 0, 0, 0);
    step();
    check_outs("mul_t5", 5'b10000, 0, 0, 0, 0, 0);

    // DIV completed by md_done 10 cycles after start
    issue(2'b10, 7'b0000001, 3'b100, 1'b1);
    check_outs("div_t1", 5'b10100, 0, 1, 1, 0, 0);
    for (int k = 2; k <= 11; k++) step();
    check_outs("div_t11", 5'b10100, 0, 1, 0, 0, 0);
    md_done_i = 1'b1;
    step();
    md_done_i = 1'b0;
    check_outs("div_done", 5'b10100, 1, 0, 0, 0, 0);
    step();

    // DIV timeout 64 cycles after start
    issue(2'b10, 7'b0000001, 3'b101, 1'b1);
    check_outs("divu_t1", 5'b10101, 0, 1, 1, 0, 0);
    for (int k = 2; k <= 64; k++) step();
    check_outs("divu_t64", 5'b10101, 0, 1, 0, 0, 0);
    step();
    check_outs("divu_timeout", 5'b10101, 0, 0, 0, 0, 1);
    step();
    check_outs("divu_after", 5'b10101, 0, 0, 0, 0, 0);
    issue(2'b10, 7'b0100000, 3'b000, 1'b1);
    check_outs("idle_after_to", 5'b00011, 1, 0, 0, 0, 0);

    // done on the timeout cycle wins
    issue(2'b10, 7'b0000001, 3'b111, 1'b1);
    for (int k = 2; k <= 64; k++) step();
    md_done_i = 1'b1;
    step();
    md_done_i = 1'b0;
    check_outs("done_wins", 5'b10111, 1, 0, 0, 0, 0);
    step();

    // flush during MUL_WAIT
    issue(2'b10, 7'b0000001, 3'b011, 1'b1);
    check_outs("mulhu_t1", 5'b10011, 0, 1, 1, 0, 0);
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    check_outs("mul_flush", 5'b10011, 0, 0, 0, 0, 0);
    step();
    step();
    check_outs("mul_flush_t4", 5'b10011, 0, 0, 0, 0, 0);
    step();
    check_outs("mul_flush_t5", 5'b10011, 0, 0, 0, 0, 0);

    // reset during DIV_WAIT
    issue(2'b10, 7'b0000001, 3'b110, 1'b1);
    step();
    check_outs("rem_t2", 5'b10110, 0, 1, 0, 0, 0);
    rst_n = 1'b0;
    step();
    check_outs("rem_reset", 5'b00000, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    md_done_i = 1'b1;
    step();
    md_done_i = 1'b0;
    check_outs("rem_post_rst", 5'b00000, 0, 0, 0, 0, 0);
`endif

    // reset overrides a simultaneous valid instruction
    issue(2'b10, 7'b0000000, 3'b100, 1'b1);
    check_outs("pre_reset", 5'b01001, 1, 0, 0, 0, 0);
    rst_n = 1'b0;
    issue(2'b10, 7'b0100000, 3'b000, 1'b1);
    check_outs("reset_valid", 5'b00000, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    issue(2'b10, 7'b0000000, 3'b010, 1'b1);
    check_outs("slt_after_rst", 5'b01100, 1, 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
